alu_arbiter: RTL and testbench

Shares one combinational 32-bit Alu between two requesters. Arbitration is round-robin. Each request's operands and control are registered and held on the ALU inputs. The block waits an op-dependent number of cycles, then returns the captured answer to the requester that issued it, using a valid/ready handshake. It sits between the instruction issue logic and the Alu instance and replaces direct per-unit ALU wiring.

---
 rtl/alu_arbiter.sv | 151 +++++++++++++++
 tb/tb_alu_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Commands are registered onto the ALU inputs; the answer is captured after an op-dependent latency.
module alu_arbiter #(
  parameter int WIDTH     = 32,
  parameter int ARITH_LAT = 1,
  parameter int DIV_LAT   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_a_or_l,
  input  logic             req0_s_or_u,
  input  logic [1:0]       req0_opcode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_a_or_l,
  input  logic             req1_s_or_u,
  input  logic [1:0]       req1_opcode,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_a_or_l,
  output logic             alu_s_or_u,
  output logic [1:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_answer,
  output logic             busy
);

  localparam int MAX_LAT = (ARITH_LAT > DIV_LAT) ? ARITH_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] ARITH_CNT = CNT_W'(ARITH_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT   = CNT_W'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_owner;
  logic               r_last_grant;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic               r_alu_a_or_l;
  logic               r_alu_s_or_u;
  logic [1:0]         r_alu_opcode;
  logic [WIDTH-1:0]   r_resp_result;

  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_accept;
  logic               w_resp_take;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic               w_sel_a_or_l;
  logic               w_sel_s_or_u;
  logic [1:0]         w_sel_opcode;
  logic               w_sel_is_div;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Ready is gated by reset_n so it drops along with the other outputs during reset.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_resp_take = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (reset_n) begin
          w_gnt0 = req0_valid && (!req1_valid || r_last_grant);
          w_gnt1 = req1_valid && (!req0_valid || !r_last_grant);
        end
        if (w_gnt0 || w_gnt1) w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (r_cnt == '0) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_resp_take = r_owner ? resp1_ready : resp0_ready;
        if (w_resp_take) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept     = w_gnt0 || w_gnt1;
  assign w_sel_a      = w_gnt1 ? req1_a      : req0_a;
  assign w_sel_b      = w_gnt1 ? req1_b      : req0_b;
  assign w_sel_a_or_l = w_gnt1 ? req1_a_or_l : req0_a_or_l;
  assign w_sel_s_or_u = w_gnt1 ? req1_s_or_u : req0_s_or_u;
  assign w_sel_opcode = w_gnt1 ? req1_opcode : req0_opcode;
  assign w_sel_is_div = !w_sel_a_or_l && (w_sel_opcode == 2'b11);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner       <= 1'b0;
      r_last_grant  <= 1'b1;
      r_cnt         <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_a_or_l  <= 1'b0;
      r_alu_s_or_u  <= 1'b0;
      r_alu_opcode  <= 2'b00;
      r_resp_result <= '0;
    end else begin
      if (w_accept) begin
        r_alu_a      <= w_sel_a;
        r_alu_b      <= w_sel_b;
        r_alu_a_or_l <= w_sel_a_or_l;
        r_alu_s_or_u <= w_sel_s_or_u;
        r_alu_opcode <= w_sel_opcode;
        r_owner      <= w_gnt1;
        r_cnt        <= w_sel_is_div ? DIV_CNT : ARITH_CNT;
      end
      if (r_state == S_EXEC) begin
        if (r_cnt != '0) r_cnt         <= r_cnt - 1'b1;
        else             r_resp_result <= alu_answer;
      end
      if (w_resp_take) r_last_grant <= r_owner;
    end
  end

  assign req0_ready  = w_gnt0;
  assign req1_ready  = w_gnt1;
  assign resp0_valid = (r_state == S_RESP) && !r_owner;
  assign resp1_valid = (r_state == S_RESP) &&  r_owner;
  assign resp_result = r_resp_result;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_a_or_l  = r_alu_a_or_l;
  assign alu_s_or_u  = r_alu_s_or_u;
  assign alu_opcode  = r_alu_opcode;
  assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a behavioural ALU on the alu_* side.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req0_ready, req0_a_or_l, req0_s_or_u;
  logic [31:0] req0_a, req0_b;
  logic [1:0]  req0_opcode;
  logic        req1_valid, req1_ready, req1_a_or_l, req1_s_or_u;
  logic [31:0] req1_a, req1_b;
  logic [1:0]  req1_opcode;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [31:0] resp_result, alu_a, alu_b, alu_answer;
  logic        alu_a_or_l, alu_s_or_u, busy;
  logic [1:0]  alu_opcode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .ARITH_LAT(1), .DIV_LAT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_a_or_l(req0_a_or_l), .req0_s_or_u(req0_s_or_u), .req0_opcode(req0_opcode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_a_or_l(req1_a_or_l), .req1_s_or_u(req1_s_or_u), .req1_opcode(req1_opcode),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_result(resp_result), .alu_a(alu_a), .alu_b(alu_b),
    .alu_a_or_l(alu_a_or_l), .alu_s_or_u(alu_s_or_u), .alu_opcode(alu_opcode),
    .alu_answer(alu_answer), .busy(busy)
  );

  // Behavioural stand-in for the external combinational ALU.
  always_comb begin
    alu_answer = '0;
    if (!alu_a_or_l) begin
      case (alu_opcode)
        2'b00: alu_answer = alu_a + alu_b;
        2'b01: alu_answer = alu_a - alu_b;
        2'b10: alu_answer = alu_s_or_u ? 32'($signed(alu_a) * $signed(alu_b)) : alu_a * alu_b;
        default: if (alu_b != 0) alu_answer = alu_s_or_u ? 32'($signed(alu_a) / $signed(alu_b)) : alu_a / alu_b;
      endcase
    end else begin
      case (alu_opcode)
        2'b00: alu_answer = alu_a & alu_b;
        2'b01: alu_answer = alu_a | alu_b;
        2'b10: alu_answer = alu_a ^ alu_b;
        default: alu_answer = ~alu_a;
      endcase
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(); step();
    checks++; if ({req0_ready, req1_ready, resp0_valid, resp1_valid, busy} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {req0_ready, req1_ready, resp0_valid, resp1_valid, busy}); end
    checks++; if ({resp_result, alu_a, alu_b, alu_a_or_l, alu_s_or_u, alu_opcode} !== '0) begin
      errors++; $display("FAIL reset_data: result=%h alu_a=%h alu_b=%h expected all zero", resp_result, alu_a, alu_b); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    req0_a = 32'd61; req0_b = 32'd11; req0_a_or_l = 0; req0_s_or_u = 0; req0_opcode = 2'b00;
    resp0_ready = 1; req0_valid = 1; #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready}); end
    step(); req0_valid = 0;
    checks++; if ({busy, resp0_valid, alu_a} !== {1'b1, 1'b0, 32'd61}) begin
      errors++; $display("FAIL single_exec: busy=%b resp0_valid=%b alu_a=%0d expected 1 0 61", busy, resp0_valid, alu_a); end
    step();
    checks++; if ({resp0_valid, resp1_valid, resp_result} !== {2'b10, 32'd72}) begin
      errors++; $display("FAIL single_resp: valid=%b result=%0d expected 10 72", {resp0_valid, resp1_valid}, resp_result); end
    step();
    checks++; if ({busy, resp0_valid} !== 2'b00) begin
      errors++; $display("FAIL single_idle: busy=%b resp0_valid=%b expected 0 0", busy, resp0_valid); end
  endtask

  task automatic test_div();
    req1_a = 32'd62; req1_b = 32'd15; req1_a_or_l = 0; req1_s_or_u = 0; req1_opcode = 2'b11;
    resp1_ready = 0; req1_valid = 1; #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++; $display("FAIL div_ready: got %b expected 01", {req0_ready, req1_ready}); end
    step(); req1_valid = 0; req1_a = 32'd999;
    for (int k = 1; k <= 5; k++) begin
      if (k < 4) begin
        checks++; if (resp1_valid !== 1'b0) begin
          errors++; $display("FAIL div_early_%0d: resp1_valid=%b expected 0", k, resp1_valid); end
      end
      step();
      checks++; if ({alu_a, alu_b, alu_a_or_l, alu_s_or_u, alu_opcode} !== {32'd62, 32'd15, 2'b00, 2'b11}) begin
        errors++; $display("FAIL div_alu_hold_%0d: alu_a=%0d alu_b=%0d op=%b expected 62 15 11", k, alu_a, alu_b, alu_opcode); end
      if (k == 4) begin
        checks++; if ({resp1_valid, resp0_valid, resp_result} !== {2'b10, 32'd4}) begin
          errors++; $display("FAIL div_resp: valid1/0=%b result=%0d expected 10 4", {resp1_valid, resp0_valid}, resp_result); end
      end
    end
    checks++; if ({resp1_valid, resp_result} !== {1'b1, 32'd4}) begin
      errors++; $display("FAIL div_hold: resp1_valid=%b result=%0d expected 1 4", resp1_valid, resp_result); end
    resp1_ready = 1;
    step();
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL div_done: busy=%b expected 0", busy); end
  endtask

  task automatic test_contention();
    int n;
    logic g;
    reset_n = 0; step(); reset_n = 1; step();
    req0_a = 32'd1;  req0_b = 32'd2; req0_a_or_l = 0; req0_s_or_u = 0; req0_opcode = 2'b00;
    req1_a = 32'd10; req1_b = 32'd3; req1_a_or_l = 0; req1_s_or_u = 0; req1_opcode = 2'b01;
    resp0_ready = 1; resp1_ready = 1; req0_valid = 1; req1_valid = 1; #1;
    for (int op = 0; op < 4; op++) begin
      n = 0;
      while (!req0_ready && !req1_ready && n < 10) begin step(); n++; end
      checks++; if (n >= 10) begin
        errors++; $display("FAIL cont_grant_timeout_%0d: no ready within 10 cycles", op); end
      g = req1_ready;
      checks++; if ({req1_ready, req0_ready} !== {op[0], ~op[0]}) begin
        errors++; $display("FAIL cont_order_%0d: ready1/0=%b expected grant %0d", op, {req1_ready, req0_ready}, op % 2); end
      step();
      n = 0;
      while (!resp0_valid && !resp1_valid && n < 10) begin step(); n++; end
      checks++; if ({resp1_valid, resp0_valid, resp_result} !== {g, ~g, (op[0] ? 32'd7 : 32'd3)}) begin
        errors++; $display("FAIL cont_result_%0d: valid1/0=%b result=%0d expected %0d", op, {resp1_valid, resp0_valid}, resp_result, op[0] ? 7 : 3); end
      step();
    end
    req0_valid = 0; req1_valid = 0;
    step(); step(); step();
  endtask

  task automatic test_backpressure();
    req0_a = 32'd5;  req0_b = 32'd6; req0_opcode = 2'b00; req0_a_or_l = 0; req0_s_or_u = 0;
    req1_a = 32'd20; req1_b = 32'd8; req1_opcode = 2'b01; req1_a_or_l = 0; req1_s_or_u = 0;
    resp0_ready = 0; resp1_ready = 0; req0_valid = 1; #1;
    step(); req0_valid = 0; req1_valid = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if ({resp0_valid, resp_result, req1_ready} !== {1'b1, 32'd11, 1'b0}) begin
        errors++; $display("FAIL bp_hold_%0d: resp0_valid=%b result=%0d req1_ready=%b expected 1 11 0", k, resp0_valid, resp_result, req1_ready); end
    end
    resp0_ready = 1;
    step();
    checks++; if ({busy, req1_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_next_accept: busy=%b req1_ready=%b expected 0 1", busy, req1_ready); end
    resp0_ready = 0; resp1_ready = 1;
    step(); req1_valid = 0;
    step();
    checks++; if ({resp1_valid, resp_result} !== {1'b1, 32'd12}) begin
      errors++; $display("FAIL bp_req1_resp: resp1_valid=%b result=%0d expected 1 12", resp1_valid, resp_result); end
    step();
  endtask

  task automatic test_reset_mid();
    int seen;
    req1_a = 32'd100; req1_b = 32'd7; req1_opcode = 2'b11; req1_a_or_l = 0; req1_s_or_u = 0;
    resp0_ready = 1; resp1_ready = 1; req1_valid = 1; #1;
    step(); step();
    req0_valid = 1;
    reset_n = 0; #1;
    checks++; if ({req0_ready, req1_ready, resp0_valid, resp1_valid, busy} !== 5'b0) begin
      errors++; $display("FAIL midrst_ctrl: got %b expected 00000", {req0_ready, req1_ready, resp0_valid, resp1_valid, busy}); end
    checks++; if ({resp_result, alu_a, alu_b, alu_a_or_l, alu_s_or_u, alu_opcode} !== '0) begin
      errors++; $display("FAIL midrst_data: result=%h alu_a=%h alu_b=%h expected all zero", resp_result, alu_a, alu_b); end
    req0_valid = 0; req1_valid = 0;
    step(); reset_n = 1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (resp0_valid || resp1_valid || busy) seen++;
    end
    checks++; if (seen !== 0) begin
      errors++; $display("FAIL midrst_no_resp: active cycles=%0d expected 0", seen); end
    req0_a = 32'd4; req0_b = 32'd4; req0_opcode = 2'b00;
    req0_valid = 1; req1_valid = 1; #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL midrst_first_grant: got %b expected 10", {req0_ready, req1_ready}); end
    step(); req0_valid = 0; req1_valid = 0;
    for (int k = 0; k < 8; k++) step();
  endtask

  task automatic test_signed_mul();
    req0_a = 32'hFFFF_FFFD; req0_b = 32'd7; req0_a_or_l = 0; req0_s_or_u = 1; req0_opcode = 2'b10;
    resp0_ready = 1; req0_valid = 1; #1;
    step(); req0_valid = 0;
    step();
    checks++; if ({resp0_valid, resp_result} !== {1'b1, 32'hFFFF_FFEB}) begin
      errors++; $display("FAIL smul_resp: resp0_valid=%b result=%h expected 1 ffffffeb", resp0_valid, resp_result); end
    step();
    checks++; if ({busy, resp_result} !== {1'b0, 32'hFFFF_FFEB}) begin
      errors++; $display("FAIL smul_keep: busy=%b result=%h expected 0 ffffffeb", busy, resp_result); end
  endtask

  initial begin
    reset_n = 0;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_a_or_l = 0; req0_s_or_u = 0; req0_opcode = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_a_or_l = 0; req1_s_or_u = 0; req1_opcode = 0;
    resp0_ready = 0; resp1_ready = 0;
    test_reset();
    test_single();
    test_div();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_signed_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
